// File: rtl/mem_arb_pkg.sv
// Shared constants for the video/CPU memory arbiter: FSM states, slot phases, steal counter width.
package mem_arb_pkg;

   localparam int CNT_W = 3;

   localparam logic [1:0] NORMAL  = 2'd0;
   localparam logic [1:0] BA_WAIT = 2'd1;
   localparam logic [1:0] STEAL   = 2'd2;

   localparam logic SLOT_VID = 1'b0;
   localparam logic SLOT_CPU = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Time-slices one RAM between a 6502 (odd slots) and a video fetcher (even slots, or all slots during a steal).
// Video data returns one cycle after its slot; the CPU is held off through cpu_ce, with cpu_rdy warning BA_DELAY slots ahead.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int BA_DELAY = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] cpu_ab,
   input  logic [7:0]  cpu_do,
   input  logic        cpu_we,
   output logic [7:0]  cpu_di,
   output logic        cpu_ce,
   output logic        cpu_rdy,
   input  logic        vid_req,
   input  logic [15:0] vid_ab,
   input  logic        vid_steal,
   output logic [7:0]  vid_data,
   output logic        vid_valid,
   output logic [15:0] ram_ab,
   output logic [7:0]  ram_do,
   output logic        ram_we,
   input  logic [7:0]  ram_di
);

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BA_DELAY);

   logic             phase;
   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic             vid_own;

   assign vid_own = (phase == SLOT_VID) || (state == STEAL);
   assign cpu_rdy = (state == NORMAL);
   assign cpu_di  = ram_di;
   assign ram_do  = cpu_do;

   always_ff @(posedge clk) begin
      if (!reset) begin
         phase     <= SLOT_VID;
         state     <= NORMAL;
         cnt       <= '0;
         vid_valid <= 1'b0;
         vid_data  <= 8'h00;
      end else begin
         phase     <= ~phase;
         vid_valid <= vid_own & vid_req;
         if (vid_own && vid_req)
            vid_data <= ram_di;

         // Dropping vid_steal always wins over the countdown.
         case (state)
            NORMAL: begin
               if (vid_steal) begin
                  state <= BA_WAIT;
                  cnt   <= CNT_LOAD;
               end
            end
            BA_WAIT: begin
               if (!vid_steal) begin
                  state <= NORMAL;
               end else if (phase == SLOT_CPU) begin
                  cnt <= cnt - CNT_ONE;
                  if (cnt == CNT_ONE)
                     state <= STEAL;
               end
            end
            STEAL: begin
               if (!vid_steal)
                  state <= NORMAL;
            end
            default: state <= NORMAL;
         endcase
      end
   end

   // During BA_WAIT a 6502 write cycle cannot be stretched, so writes go through and reads stall.
   always_comb begin
      ram_ab = vid_ab;
      ram_we = 1'b0;
      cpu_ce = 1'b0;
      if (phase == SLOT_CPU) begin
         case (state)
            NORMAL: begin
               ram_ab = cpu_ab;
               ram_we = cpu_we;
               cpu_ce = 1'b1;
            end
            BA_WAIT: begin
               ram_ab = cpu_ab;
               ram_we = cpu_we;
               cpu_ce = cpu_we;
            end
            default: begin
               ram_ab = vid_ab;
            end
         endcase
      end
      if (!reset) begin
         ram_we = 1'b0;
         cpu_ce = 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle bus checks plus a scoreboard on the video return path.
module tb_mem_arbiter;

   typedef struct {
      int         cyc;
      logic [7:0] dat;
   } exp_t;

   logic        clk;
   logic        reset;
   logic [15:0] cpu_ab;
   logic [7:0]  cpu_do;
   logic        cpu_we;
   logic        vid_req;
   logic [15:0] vid_ab;
   logic        vid_steal;

   logic [7:0]  cpu_di,   cpu_di_b;
   logic        cpu_ce,   cpu_ce_b;
   logic        cpu_rdy,  cpu_rdy_b;
   logic [7:0]  vid_data, vid_data_b;
   logic        vid_valid, vid_valid_b;
   logic [15:0] ram_ab,   ram_ab_b;
   logic [7:0]  ram_do,   ram_do_b;
   logic        ram_we,   ram_we_b;
   logic [7:0]  ram_di,   ram_di_b;

   logic [7:0]  mem   [0:65535];
   logic [7:0]  mem_b [0:65535];

   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;
   bit   mon_en = 1'b0;
   exp_t sb [$];
   exp_t head;

   mem_arbiter #(.BA_DELAY(3)) dut (
      .clk(clk), .reset(reset),
      .cpu_ab(cpu_ab), .cpu_do(cpu_do), .cpu_we(cpu_we),
      .cpu_di(cpu_di), .cpu_ce(cpu_ce), .cpu_rdy(cpu_rdy),
      .vid_req(vid_req), .vid_ab(vid_ab), .vid_steal(vid_steal),
      .vid_data(vid_data), .vid_valid(vid_valid),
      .ram_ab(ram_ab), .ram_do(ram_do), .ram_we(ram_we), .ram_di(ram_di)
   );

   mem_arbiter #(.BA_DELAY(1)) dut_b (
      .clk(clk), .reset(reset),
      .cpu_ab(cpu_ab), .cpu_do(cpu_do), .cpu_we(cpu_we),
      .cpu_di(cpu_di_b), .cpu_ce(cpu_ce_b), .cpu_rdy(cpu_rdy_b),
      .vid_req(vid_req), .vid_ab(vid_ab), .vid_steal(vid_steal),
      .vid_data(vid_data_b), .vid_valid(vid_valid_b),
      .ram_ab(ram_ab_b), .ram_do(ram_do_b), .ram_we(ram_we_b), .ram_di(ram_di_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   assign ram_di   = mem[ram_ab];
   assign ram_di_b = mem_b[ram_ab_b];

   always @(posedge clk) begin
      if (ram_we === 1'b1)   mem[ram_ab]     <= ram_do;
      if (ram_we_b === 1'b1) mem_b[ram_ab_b] <= ram_do_b;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every vid_valid pulse must match the oldest pending expectation, in the expected cycle.
   always @(negedge clk) begin
      if (mon_en) begin
         if (sb.size() > 0 && sb[0].cyc < cyc) begin
            n_vec++;
            n_err++;
            $display("FAIL vid_missing: got no vid_valid, expected data %0h in cycle %0d", sb[0].dat, sb[0].cyc);
            void'(sb.pop_front());
         end
         if (vid_valid === 1'b1) begin
            if (sb.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL vid_unexpected: got vid_valid with data %0h, expected none (cycle %0d)", vid_data, cyc);
            end else begin
               head = sb.pop_front();
               chk("vid_cycle", cyc, head.cyc);
               chk("vid_data", vid_data, head.dat);
            end
         end
      end
   end

   task automatic step(input logic [15:0] ca, input logic [7:0] cd, input logic cw,
                       input logic vr, input logic [15:0] va, input logic st,
                       input logic e_ce, input logic e_we, input logic e_rdy,
                       input logic e_push, input logic [7:0] e_dat);
      exp_t t;
      @(negedge clk);
      reset     = 1'b1;
      cpu_ab    = ca;
      cpu_do    = cd;
      cpu_we    = cw;
      vid_req   = vr;
      vid_ab    = va;
      vid_steal = st;
      #1;
      chk("cpu_ce", cpu_ce, e_ce);
      chk("ram_we", ram_we, e_we);
      chk("cpu_rdy", cpu_rdy, e_rdy);
      chk("ram_do", ram_do, cd);
      if (e_ce) chk("ram_ab_cpu", ram_ab, ca);
      if (e_push) begin
         chk("ram_ab_vid", ram_ab, va);
         t.cyc = cyc + 1;
         t.dat = e_dat;
         sb.push_back(t);
      end
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) begin
         mem[i]   = 8'(i) ^ 8'hA5;
         mem_b[i] = 8'(i) ^ 8'hA5;
      end
      reset = 1'b0; cpu_ab = 16'h0011; cpu_do = 8'hCC; cpu_we = 1'b1;
      vid_req = 1'b1; vid_ab = 16'h0000; vid_steal = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_cpu_ce", cpu_ce, 1'b0);
      chk("rst_ram_we", ram_we, 1'b0);
      chk("rst_cpu_rdy", cpu_rdy, 1'b1);
      chk("rst_vid_valid", vid_valid, 1'b0);
      chk("rst_vid_data", vid_data, 8'h00);
      mon_en = 1'b1;

      // Interleave: CPU write to 0x11, video reads in every even slot
      step(16'h0011, 8'h27, 1, 1, 16'h0017, 0,  0, 0, 1,  1, 8'hB2);
      step(16'h0011, 8'h27, 1, 1, 16'h0017, 0,  1, 1, 1,  0, 8'h00);
      step(16'h0011, 8'h00, 0, 1, 16'h0011, 0,  0, 0, 1,  1, 8'h27);
      step(16'h0017, 8'h00, 0, 0, 16'h0000, 0,  1, 0, 1,  0, 8'h00);
      chk("cpu_di_read", cpu_di, 8'hB2);
      step(16'h0017, 8'h00, 0, 1, 16'h0017, 0,  0, 0, 1,  1, 8'hB2);
      step(16'h0000, 8'h00, 0, 0, 16'h0000, 0,  1, 0, 1,  0, 8'h00);

      // Steal with reads: three stalled CPU slots, then every slot is video
      step(16'h0000, 8'h00, 0, 0, 16'h0000, 1,  0, 0, 1,  0, 8'h00);
      step(16'h0005, 8'h00, 0, 0, 16'h0000, 1,  0, 0, 0,  0, 8'h00);
      step(16'h0000, 8'h00, 0, 1, 16'h0020, 1,  0, 0, 0,  1, 8'h85);
      step(16'h0005, 8'h00, 0, 1, 16'h0020, 1,  0, 0, 0,  0, 8'h00);
      step(16'h0000, 8'h00, 0, 0, 16'h0000, 1,  0, 0, 0,  0, 8'h00);
      step(16'h0005, 8'h00, 0, 1, 16'h0020, 1,  0, 0, 0,  0, 8'h00);
      chk("vid_data_hold", vid_data, 8'h85);
      step(16'h0000, 8'h00, 0, 1, 16'h0021, 1,  0, 0, 0,  1, 8'h84);
      step(16'h0011, 8'hEE, 1, 1, 16'h0022, 1,  0, 0, 0,  1, 8'h87);
      step(16'h0000, 8'h00, 0, 1, 16'h0023, 1,  0, 0, 0,  1, 8'h86);
      step(16'h0005, 8'h00, 0, 1, 16'h0024, 0,  0, 0, 0,  1, 8'h81);
      step(16'h0000, 8'h00, 0, 0, 16'h0000, 0,  0, 0, 1,  0, 8'h00);
      step(16'h0005, 8'h00, 0, 0, 16'h0000, 0,  1, 0, 1,  0, 8'h00);

      // Steal with a write in BA_WAIT: write lands, STEAL timing unchanged
      step(16'h0000, 8'h00, 0, 0, 16'h0000, 1,  0, 0, 1,  0, 8'h00);
      step(16'h0016, 8'h21, 1, 0, 16'h0000, 1,  1, 1, 0,  0, 8'h00);
      step(16'h0000, 8'h00, 0, 1, 16'h0016, 1,  0, 0, 0,  1, 8'h21);
      step(16'h0005, 8'h00, 0, 0, 16'h0000, 1,  0, 0, 0,  0, 8'h00);
      step(16'h0000, 8'h00, 0, 0, 16'h0000, 1,  0, 0, 0,  0, 8'h00);
      step(16'h0005, 8'h00, 0, 1, 16'h0030, 1,  0, 0, 0,  0, 8'h00);
      step(16'h0000, 8'h00, 0, 1, 16'h0030, 1,  0, 0, 0,  1, 8'h95);
      step(16'h0005, 8'h00, 0, 1, 16'h0031, 1,  0, 0, 0,  1, 8'h94);
      step(16'h0000, 8'h00, 0, 1, 16'h0032, 1,  0, 0, 0,  1, 8'h97);

      // One-edge reset while in STEAL
      @(negedge clk);
      reset = 1'b0; cpu_ab = 16'h0011; cpu_do = 8'hCC; cpu_we = 1'b1;
      vid_req = 1'b1; vid_ab = 16'h0033; vid_steal = 1'b1;
      #1;
      chk("midrst_ram_we", ram_we, 1'b0);
      chk("midrst_cpu_ce", cpu_ce, 1'b0);
      step(16'h0040, 8'h55, 1, 1, 16'h0011, 0,  0, 0, 1,  1, 8'h27);
      chk("midrst_vid_valid", vid_valid, 1'b0);
      chk("midrst_vid_data", vid_data, 8'h00);
      step(16'h0040, 8'h55, 1, 0, 16'h0000, 0,  1, 1, 1,  0, 8'h00);

      // Early release after the first BA_WAIT CPU slot
      step(16'h0000, 8'h00, 0, 0, 16'h0000, 1,  0, 0, 1,  0, 8'h00);
      step(16'h0005, 8'h00, 0, 0, 16'h0000, 1,  0, 0, 0,  0, 8'h00);
      step(16'h0000, 8'h00, 0, 0, 16'h0000, 0,  0, 0, 0,  0, 8'h00);
      step(16'h0040, 8'h00, 0, 0, 16'h0000, 0,  1, 0, 1,  0, 8'h00);
      chk("cpu_di_release", cpu_di, 8'h55);
      step(16'h0000, 8'h00, 0, 0, 16'h0000, 0,  0, 0, 1,  0, 8'h00);
      step(16'h0005, 8'h00, 0, 0, 16'h0000, 0,  1, 0, 1,  0, 8'h00);

      // BA_DELAY=1 instance: STEAL after a single CPU slot
      step(16'h0000, 8'h00, 0, 0, 16'h0000, 1,  0, 0, 1,  0, 8'h00);
      step(16'h0005, 8'h00, 0, 1, 16'h0050, 1,  0, 0, 0,  0, 8'h00);
      chk("d1_cpu_rdy", cpu_rdy_b, 1'b0);
      chk("d1_cpu_ce_wait", cpu_ce_b, 1'b0);
      step(16'h0000, 8'h00, 0, 0, 16'h0000, 1,  0, 0, 0,  0, 8'h00);
      chk("d1_no_vid_in_wait", vid_valid_b, 1'b0);
      step(16'h0005, 8'h00, 0, 1, 16'h0050, 1,  0, 0, 0,  0, 8'h00);
      chk("d1_cpu_ce_steal", cpu_ce_b, 1'b0);
      chk("d1_ram_ab_steal", ram_ab_b, 16'h0050);
      step(16'h0000, 8'h00, 0, 0, 16'h0000, 0,  0, 0, 0,  0, 8'h00);
      chk("d1_vid_valid", vid_valid_b, 1'b1);
      chk("d1_vid_data", vid_data_b, 8'hF5);
      step(16'h0005, 8'h00, 0, 0, 16'h0000, 0,  1, 0, 1,  0, 8'h00);
      step(16'h0000, 8'h00, 0, 0, 16'h0000, 0,  0, 0, 1,  0, 8'h00);

      repeat (2) @(negedge clk);
      #1;
      chk("sb_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have a parameter BA_DELAY, default 3, giving the number of CPU slots between cpu_rdy falling and full video ownership; legal range 1..7.
REQ-002 The block SHALL have the port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port reset, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have the port cpu_ab, input, 16 bits: 6502 address.
REQ-005 The block SHALL have the port cpu_do, input, 8 bits: 6502 write data.
REQ-006 The block SHALL have the port cpu_we, input, 1 bit: 6502 write strobe (1 = write).
REQ-007 The block SHALL have the port cpu_di, output, 8 bits: read data to the 6502, combinational copy of ram_di.
REQ-008 The block SHALL have the port cpu_ce, output, 1 bit: the 6502 advances on this clock edge only when high.
REQ-009 The block SHALL have the port cpu_rdy, output, 1 bit: bus-available flag; low announces or holds a video steal.
REQ-010 The block SHALL have the port vid_req, input, 1 bit: the video fetcher requests a read in the current video-owned slot.
REQ-011 The block SHALL have the port vid_ab, input, 16 bits: video fetch address.
REQ-012 The block SHALL have the port vid_steal, input, 1 bit: level request for exclusive bus ownership (badline).
REQ-013 The block SHALL have the port vid_data, output, 8 bits: registered video read data.
REQ-014 The block SHALL have the port vid_valid, output, 1 bit: one-cycle pulse; vid_data is valid when high.
REQ-015 The block SHALL have the port ram_ab, output, 16 bits: shared RAM address.
REQ-016 The block SHALL have the port ram_do, output, 8 bits: shared RAM write data, always equal to cpu_do.
REQ-017 The block SHALL have the port ram_we, output, 1 bit: shared RAM write enable; the RAM writes on the rising edge of clk.
REQ-018 The block SHALL have the port ram_di, input, 8 bits: RAM read data, asynchronous, valid in the same cycle as ram_ab.

Function
REQ-019 A 1-bit phase register SHALL toggle every clock: phase 0 is the video slot and phase 1 is the CPU slot.
REQ-020 The state machine SHALL have exactly three states: NORMAL, BA_WAIT and STEAL.
REQ-021 In NORMAL with vid_steal=1 at an edge, the next state SHALL be BA_WAIT, with the slot counter loaded to BA_DELAY.
REQ-022 In BA_WAIT, each phase-1 cycle SHALL decrement the counter; when a phase-1 cycle finds the counter at 1, the next state SHALL be STEAL.
REQ-023 In BA_WAIT or STEAL, vid_steal=0 at an edge SHALL return the state to NORMAL, taking priority over the counter.
REQ-024 cpu_rdy SHALL equal (state==NORMAL), which makes it registered and lets it change one cycle after vid_steal is sampled.
REQ-025 In a phase-0 slot, the video path SHALL own the bus: ram_ab=vid_ab and ram_we=0.
REQ-026 In a phase-1 slot in NORMAL, the CPU SHALL own the bus: ram_ab=cpu_ab, ram_we=cpu_we and cpu_ce=1.
REQ-027 In a phase-1 slot in BA_WAIT, writes SHALL complete: if cpu_we=1 then ram_ab=cpu_ab, ram_we=1 and cpu_ce=1.
REQ-028 In a phase-1 slot in BA_WAIT, reads SHALL stall: if cpu_we=0 then ram_we=0 and cpu_ce=0, and the counter still decrements.
REQ-029 In a phase-1 slot in STEAL, the video path SHALL own the bus: ram_ab=vid_ab, ram_we=0 and cpu_ce=0.
REQ-030 cpu_ce SHALL be 0 in every phase-0 cycle, and cpu_we SHALL be ignored in those cycles.
REQ-031 In a video-owned cycle with vid_req=1, the block SHALL register vid_data<=ram_di and pulse vid_valid=1 on the next cycle.
REQ-032 In a video-owned cycle with vid_req=0, the block SHALL leave vid_valid=0 on the next cycle and hold vid_data.
REQ-033 vid_req in a CPU-owned slot SHALL be ignored, with no queueing.
REQ-034 ram_we SHALL never be 1 unless cpu_ce=1 in the same cycle.

Reset
REQ-035 reset=0 at an edge SHALL set phase=0, state=NORMAL, counter=0, cpu_rdy=1, vid_valid=0 and vid_data=8'h00.
REQ-036 Reset SHALL take priority over every other event, including reset arriving mid-steal or mid-BA_WAIT; there SHALL be no partial RAM write in the reset cycle (ram_we=0 while reset=0).
REQ-037 During reset, cpu_ce SHALL be 0.

Structure
REQ-038 A shared package mem_arb_pkg SHALL hold the state enumeration (NORMAL, BA_WAIT, STEAL), the phase constants (SLOT_VID=0, SLOT_CPU=1) and the counter width (3).
REQ-039 The block SHALL be a single module with no sub-module; the RAM array stays outside it.

Verification
REQ-040 The bench SHALL check interleave: after reset, with the CPU writing 8'h27 to 16'h0011 and vid_req=1 with vid_ab=16'h0017, RAM[0x11]==8'h27, and vid_data==RAM[0x17] with vid_valid one cycle after each phase-0 slot.
REQ-041 The bench SHALL check steal with reads: vid_steal rises in NORMAL, CPU issuing reads -> cpu_rdy=0 on the next cycle, cpu_ce=0 for 3 CPU slots, then STEAL with vid_valid on every cycle while vid_req=1.
REQ-042 The bench SHALL check steal with writes: during BA_WAIT with the CPU writing 8'h21 to 16'h0016 -> the write lands and cpu_ce=1 in that slot, and the STEAL entry time is unchanged.
REQ-043 The bench SHALL check early release: vid_steal drops after the first BA_WAIT CPU slot -> NORMAL on the next edge, cpu_rdy=1, and the next phase-1 slot gives cpu_ce=1.
REQ-044 The bench SHALL check reset mid-steal: reset=0 for one edge while in STEAL -> cpu_rdy=1, vid_valid=0, phase=0, and ram_we=0 throughout.
REQ-045 The bench SHALL check BA_DELAY=1: a steal request -> STEAL after exactly one CPU slot.
